ma_stage: RTL and testbench



---
 rtl/ma_stage_pkg.sv | 26 ++
 rtl/dmem_if_fsm.sv | 89 ++++++++
 rtl/pipereg.sv | 25 ++
 rtl/ma_stage.sv | 106 ++++++++++
 tb/tb_ma_stage.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ma_stage_pkg.sv
// Pipeline definitions shared by the memory-access stage: control bundle
// widths, MA control bit positions and the data-memory interface FSM states.
package ma_stage_pkg;

    localparam int WB_W      = 3;
    localparam int MA_W      = 2;

    // MA control bundle bit positions
    localparam int MA_RE_BIT = 0;
    localparam int MA_WE_BIT = 1;

    // MA/WB register field layout for the default widths (Rds in the LSBs)
    localparam int MAWB_DEF_DATA_W  = 32;
    localparam int MAWB_DEF_RADDR_W = 5;
    localparam int MAWB_RDS_LSB     = 0;
    localparam int MAWB_PC_LSB      = MAWB_RDS_LSB + MAWB_DEF_RADDR_W;
    localparam int MAWB_RSLT_LSB    = MAWB_PC_LSB + MAWB_DEF_DATA_W;
    localparam int MAWB_WB_LSB      = MAWB_RSLT_LSB + MAWB_DEF_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory request/ack sequencer for the MA stage. Issues one aligned
// access per memory instruction, holds the request stable until acked,
// and captures load data for the single DONE cycle.
module dmem_if_fsm
    import ma_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ack,
    input  logic [DATA_W-1:0] rdata,
    output logic              req,
    output logic              we,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              stall_req,
    output logic              misaligned,
    output logic              done,
    output logic [DATA_W-1:0] load_data
);

    dmem_state_t state;

    logic mem_op;
    logic aligned;
    logic issue;

    assign mem_op  = mem_re | mem_we;
    assign aligned = (addr[1:0] == 2'b00);
    assign issue   = (state == ST_IDLE) && mem_op && aligned;

    // Stall from the moment an access is accepted until the ack has been seen
    assign stall_req = issue || (state == ST_BUSY);
    assign done      = (state == ST_DONE);

    // FSM with registered request, misalignment pulse and load-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req        <= 1'b0;
            we         <= 1'b0;
            req_addr   <= '0;
            wdata      <= '0;
            misaligned <= 1'b0;
            load_data  <= '0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (aligned) begin
                            // Both RE and WE set resolves to a store
                            req      <= 1'b1;
                            we       <= mem_we;
                            req_addr <= {addr[DATA_W-1:2], 2'b00};
                            wdata    <= st_data;
                            state    <= ST_BUSY;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ack) begin
                        req <= 1'b0;
                        if (!we) begin
                            load_data <= rdata;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EXMA advances on this edge, so the op is not re-issued
                    state <= ST_IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipereg.sv
// Generic pipeline register with stall (hold) and flush (clear) controls.
// Flush wins over both stall and load.
module pipereg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register: clear on flush, hold on stall, otherwise load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: consumes the EX/MA register, drives data-memory
// accesses, supplies forwarding data to EX and owns the MA/WB register.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int WB_W    = ma_stage_pkg::WB_W,
    parameter int MA_W    = ma_stage_pkg::MA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WB_W-1:0]    i_EXMA_WB,
    input  logic [MA_W-1:0]    i_EXMA_MEM,
    input  logic [DATA_W-1:0]  i_EXMA_ALU_rslt,
    input  logic [DATA_W-1:0]  i_EXMA_Rs2_val,
    input  logic [DATA_W-1:0]  i_EXMA_PC,
    input  logic [RADDR_W-1:0] i_EXMA_Rds_addr,
    input  logic [DATA_W-1:0]  i_Data_From_WB,
    input  logic               i_Fwrd_St,
    input  logic               i_MAWB_flush,
    input  logic               i_DMem_ack,
    input  logic [DATA_W-1:0]  i_DMem_rdata,
    output logic               o_DMem_req,
    output logic               o_DMem_we,
    output logic [DATA_W-1:0]  o_DMem_addr,
    output logic [DATA_W-1:0]  o_DMem_wdata,
    output logic               o_Stall_Req,
    output logic               o_Misaligned,
    output logic [DATA_W-1:0]  o_Data_To_EX,
    output logic [WB_W-1:0]    o_MAWB_WB,
    output logic [DATA_W-1:0]  o_MAWB_Rslt,
    output logic [DATA_W-1:0]  o_MAWB_PC,
    output logic [RADDR_W-1:0] o_MAWB_Rds_addr
);

    localparam int MAWB_W = WB_W + 2*DATA_W + RADDR_W;

    logic              ma_re;
    logic              ma_we;
    logic              mem_op;
    logic              is_load;
    logic              misaligned_op;
    logic [DATA_W-1:0] st_data;
    logic              fsm_done;
    logic [DATA_W-1:0] load_data;
    logic [WB_W-1:0]   mawb_wb_p0;
    logic [DATA_W-1:0] mawb_rslt_p0;
    logic [MAWB_W-1:0] mawb_d_p0;
    logic [MAWB_W-1:0] mawb_q_p1;

    assign ma_re   = i_EXMA_MEM[MA_RE_BIT];
    assign ma_we   = i_EXMA_MEM[MA_WE_BIT];
    assign mem_op  = ma_re | ma_we;
    assign is_load = ma_re & ~ma_we;

    // A memory op that cannot issue: an aligned op stalls, so only a
    // misaligned one can reach the MA/WB register from IDLE unserviced.
    assign misaligned_op = mem_op && (i_EXMA_ALU_rslt[1:0] != 2'b00);

    // Load-to-store forwarding of the store data
    assign st_data = i_Fwrd_St ? i_Data_From_WB : i_EXMA_Rs2_val;

    dmem_if_fsm #(
        .DATA_W (DATA_W)
    ) u_dmem_if_fsm (
        .clk        (clk),
        .reset      (reset),
        .mem_re     (ma_re),
        .mem_we     (ma_we),
        .addr       (i_EXMA_ALU_rslt),
        .st_data    (st_data),
        .ack        (i_DMem_ack),
        .rdata      (i_DMem_rdata),
        .req        (o_DMem_req),
        .we         (o_DMem_we),
        .req_addr   (o_DMem_addr),
        .wdata      (o_DMem_wdata),
        .stall_req  (o_Stall_Req),
        .misaligned (o_Misaligned),
        .done       (fsm_done),
        .load_data  (load_data)
    );

    // Stage result: captured load data only in the DONE cycle of a load
    assign mawb_rslt_p0 = (fsm_done && is_load) ? load_data : i_EXMA_ALU_rslt;
    assign mawb_wb_p0   = misaligned_op ? '0 : i_EXMA_WB;
    assign o_Data_To_EX = mawb_rslt_p0;

    assign mawb_d_p0 = {mawb_wb_p0, mawb_rslt_p0, i_EXMA_PC, i_EXMA_Rds_addr};

    // ---- MA -> WB boundary ----
    pipereg #(
        .WIDTH (MAWB_W)
    ) u_mawb_reg (
        .clk   (clk),
        .reset (reset),
        .stall (o_Stall_Req),
        .flush (i_MAWB_flush),
        .d     (mawb_d_p0),
        .q     (mawb_q_p1)
    );

    assign {o_MAWB_WB, o_MAWB_Rslt, o_MAWB_PC, o_MAWB_Rds_addr} = mawb_q_p1;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: a small memory responder with programmable
// wait states, a scoreboard of expected MA/WB contents, and checks on the
// request/stall timing of each memory instruction.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_EXMA_WB;
    logic [1:0]  i_EXMA_MEM;
    logic [31:0] i_EXMA_ALU_rslt;
    logic [31:0] i_EXMA_Rs2_val;
    logic [31:0] i_EXMA_PC;
    logic [4:0]  i_EXMA_Rds_addr;
    logic [31:0] i_Data_From_WB;
    logic        i_Fwrd_St;
    logic        i_MAWB_flush;
    logic        i_DMem_ack;
    logic [31:0] i_DMem_rdata;
    logic        o_DMem_req;
    logic        o_DMem_we;
    logic [31:0] o_DMem_addr;
    logic [31:0] o_DMem_wdata;
    logic        o_Stall_Req;
    logic        o_Misaligned;
    logic [31:0] o_Data_To_EX;
    logic [2:0]  o_MAWB_WB;
    logic [31:0] o_MAWB_Rslt;
    logic [31:0] o_MAWB_PC;
    logic [4:0]  o_MAWB_Rds_addr;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0]  wb;
        logic [31:0] rslt;
        logic [31:0] pc;
        logic [4:0]  rds;
    } mawb_t;

    mawb_t sb[$];
    logic  mis_after;

    ma_stage dut (
        .clk             (clk),
        .reset           (reset),
        .i_EXMA_WB       (i_EXMA_WB),
        .i_EXMA_MEM      (i_EXMA_MEM),
        .i_EXMA_ALU_rslt (i_EXMA_ALU_rslt),
        .i_EXMA_Rs2_val  (i_EXMA_Rs2_val),
        .i_EXMA_PC       (i_EXMA_PC),
        .i_EXMA_Rds_addr (i_EXMA_Rds_addr),
        .i_Data_From_WB  (i_Data_From_WB),
        .i_Fwrd_St       (i_Fwrd_St),
        .i_MAWB_flush    (i_MAWB_flush),
        .i_DMem_ack      (i_DMem_ack),
        .i_DMem_rdata    (i_DMem_rdata),
        .o_DMem_req      (o_DMem_req),
        .o_DMem_we       (o_DMem_we),
        .o_DMem_addr     (o_DMem_addr),
        .o_DMem_wdata    (o_DMem_wdata),
        .o_Stall_Req     (o_Stall_Req),
        .o_Misaligned    (o_Misaligned),
        .o_Data_To_EX    (o_Data_To_EX),
        .o_MAWB_WB       (o_MAWB_WB),
        .o_MAWB_Rslt     (o_MAWB_Rslt),
        .o_MAWB_PC       (o_MAWB_PC),
        .o_MAWB_Rds_addr (o_MAWB_Rds_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        mawb_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".mawb_wb"},   {61'd0, o_MAWB_WB},       {61'd0, e.wb});
            chk({tag, ".mawb_rslt"}, {32'd0, o_MAWB_Rslt},     {32'd0, e.rslt});
            chk({tag, ".mawb_pc"},   {32'd0, o_MAWB_PC},       {32'd0, e.pc});
            chk({tag, ".mawb_rds"},  {59'd0, o_MAWB_Rds_addr}, {59'd0, e.rds});
        end
    endtask

    task automatic push_exp(input logic [2:0] wb, input logic [31:0] rslt,
                            input logic [31:0] pc, input logic [4:0] rds);
        mawb_t e;
        e.wb = wb; e.rslt = rslt; e.pc = pc; e.rds = rds;
        sb.push_back(e);
    endtask

    // Present one EXMA instruction, serve memory with 'waits' wait states,
    // and check stall/request timing once the instruction leaves the stage.
    task automatic run_op(input string tag,
                          input logic [2:0] wb, input logic [1:0] ma,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [4:0] rds,
                          input logic fwd, input logic [31:0] wbd, input logic fl,
                          input int waits, input logic [31:0] rdata,
                          input int exp_stall, input int exp_req,
                          input logic [31:0] exp_addr, input logic exp_we,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_fwd);
        int          req_cnt   = 0;
        int          stall_cnt = 0;
        logic        passed    = 1'b0;
        logic        unstable  = 1'b0;
        logic        stall_now;
        logic [31:0] dte       = '0;
        logic [31:0] r_addr    = '0;
        logic [31:0] r_wdata   = '0;
        logic        r_we      = 1'b0;
        i_EXMA_WB       = wb;
        i_EXMA_MEM      = ma;
        i_EXMA_ALU_rslt = alu;
        i_EXMA_Rs2_val  = rs2;
        i_EXMA_PC       = pc;
        i_EXMA_Rds_addr = rds;
        i_Fwrd_St       = fwd;
        i_Data_From_WB  = wbd;
        i_MAWB_flush    = fl;
        for (int c = 0; c < 40; c++) begin
            if (o_DMem_req) begin
                i_DMem_ack   = (req_cnt == waits);
                i_DMem_rdata = (req_cnt == waits) ? rdata : 32'h0BAD_0BAD;
                if (req_cnt == 0) begin
                    r_addr = o_DMem_addr; r_we = o_DMem_we; r_wdata = o_DMem_wdata;
                end else if (o_DMem_addr !== r_addr || o_DMem_we !== r_we ||
                             o_DMem_wdata !== r_wdata) begin
                    unstable = 1'b1;
                end
                req_cnt++;
            end else begin
                i_DMem_ack = 1'b0;
            end
            #1;
            if (o_Stall_Req) stall_cnt++;
            stall_now = o_Stall_Req;
            dte       = o_Data_To_EX;
            @(posedge clk); #1;
            if (!stall_now) begin
                passed = 1'b1;
                break;
            end
        end
        i_DMem_ack   = 1'b0;
        i_MAWB_flush = 1'b0;
        mis_after    = o_Misaligned;
        chk({tag, ".completed"}, {63'd0, passed}, 64'd1);
        chk({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        chk({tag, ".req_cycles"}, 64'(req_cnt), 64'(exp_req));
        chk({tag, ".data_to_ex"}, {32'd0, dte}, {32'd0, exp_fwd});
        if (exp_req > 0) begin
            chk({tag, ".req_addr"},  {32'd0, r_addr},  {32'd0, exp_addr});
            chk({tag, ".req_we"},    {63'd0, r_we},    {63'd0, exp_we});
            chk({tag, ".req_wdata"}, {32'd0, r_wdata}, {32'd0, exp_wdata});
            chk({tag, ".req_stable"}, {63'd0, unstable}, 64'd0);
        end
        chk({tag, ".req_dropped"}, {63'd0, o_DMem_req}, 64'd0);
        pop_cmp(tag);
    endtask

    task automatic drive_nop();
        i_EXMA_WB = '0; i_EXMA_MEM = '0; i_EXMA_ALU_rslt = '0; i_EXMA_Rs2_val = '0;
        i_EXMA_PC = '0; i_EXMA_Rds_addr = '0; i_Fwrd_St = 1'b0; i_Data_From_WB = '0;
        i_MAWB_flush = 1'b0;
    endtask

    initial begin
        int   guard;
        logic seen;
        reset        = 1'b1;
        i_DMem_ack   = 1'b0;
        i_DMem_rdata = '0;
        drive_nop();
        @(posedge clk); @(posedge clk); #1;

        // Reset values
        chk("rst.req",        {63'd0, o_DMem_req},      64'd0);
        chk("rst.we",         {63'd0, o_DMem_we},       64'd0);
        chk("rst.misaligned", {63'd0, o_Misaligned},    64'd0);
        chk("rst.addr",       {32'd0, o_DMem_addr},     64'd0);
        chk("rst.wdata",      {32'd0, o_DMem_wdata},    64'd0);
        chk("rst.stall",      {63'd0, o_Stall_Req},     64'd0);
        chk("rst.mawb_wb",    {61'd0, o_MAWB_WB},       64'd0);
        chk("rst.mawb_rslt",  {32'd0, o_MAWB_Rslt},     64'd0);
        chk("rst.mawb_pc",    {32'd0, o_MAWB_PC},       64'd0);
        chk("rst.mawb_rds",   {59'd0, o_MAWB_Rds_addr}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain ALU op: no stall, result straight through
        push_exp(3'b101, 32'h0000_1234, 32'h0000_0040, 5'd5);
        run_op("alu", 3'b101, 2'b00, 32'h0000_1234, 32'h0, 32'h40, 5'd5, 1'b0, 32'h0, 1'b0,
               0, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0000_1234);

        // Load, zero-wait ack
        push_exp(3'b011, 32'hDEAD_BEEF, 32'h0000_0044, 5'd7);
        run_op("load0", 3'b011, 2'b01, 32'h100, 32'h1111, 32'h44, 5'd7, 1'b0, 32'h0, 1'b0,
               0, 32'hDEAD_BEEF, 2, 1, 32'h100, 1'b0, 32'h1111, 32'hDEAD_BEEF);

        // Store with three wait states
        push_exp(3'b110, 32'h0000_0200, 32'h0000_0048, 5'd9);
        run_op("store3w", 3'b110, 2'b10, 32'h200, 32'h55, 32'h48, 5'd9, 1'b0, 32'h0, 1'b0,
               3, 32'h0, 5, 4, 32'h200, 1'b1, 32'h55, 32'h200);

        // Store data forwarded from WB
        push_exp(3'b100, 32'h0000_0300, 32'h0000_004C, 5'd3);
        run_op("storefwd", 3'b100, 2'b10, 32'h300, 32'h1, 32'h4C, 5'd3, 1'b1, 32'hCAFE, 1'b0,
               0, 32'h0, 2, 1, 32'h300, 1'b1, 32'hCAFE, 32'h300);

        // RE and WE both set: handled as a store, result is the ALU value
        push_exp(3'b001, 32'h0000_0404, 32'h0000_0050, 5'd4);
        run_op("rewe", 3'b001, 2'b11, 32'h404, 32'h77, 32'h50, 5'd4, 1'b0, 32'h0, 1'b0,
               1, 32'hFFFF_FFFF, 3, 2, 32'h404, 1'b1, 32'h77, 32'h404);

        // Misaligned load: no access, WB control cleared, one-cycle pulse
        push_exp(3'b000, 32'h0000_0102, 32'h0000_0054, 5'd6);
        run_op("misalign", 3'b011, 2'b01, 32'h102, 32'h0, 32'h54, 5'd6, 1'b0, 32'h0, 1'b0,
               0, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h102);
        chk("misalign.pulse", {63'd0, mis_after}, 64'd1);
        drive_nop();
        @(posedge clk); #1;
        chk("misalign.pulse_end", {63'd0, o_Misaligned}, 64'd0);

        // Flush clears MA/WB despite a valid instruction
        push_exp(3'b000, 32'h0, 32'h0, 5'd0);
        run_op("flush", 3'b111, 2'b00, 32'h999, 32'h0, 32'h58, 5'd8, 1'b0, 32'h0, 1'b1,
               0, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h999);

        // Leave nonzero contents in MA/WB ahead of the reset test
        push_exp(3'b010, 32'h0000_ABCD, 32'h0000_005C, 5'd12);
        run_op("alu2", 3'b010, 2'b00, 32'hABCD, 32'h0, 32'h5C, 5'd12, 1'b0, 32'h0, 1'b0,
               0, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'hABCD);

        // Reset while an access is outstanding; late ack must be ignored
        i_EXMA_WB = 3'b011; i_EXMA_MEM = 2'b01; i_EXMA_ALU_rslt = 32'h400;
        i_EXMA_PC = 32'h60; i_EXMA_Rds_addr = 5'd2;
        seen  = 1'b0;
        guard = 0;
        while (!seen && guard < 10) begin
            @(posedge clk); #1;
            seen = o_DMem_req;
            guard++;
        end
        chk("rstbusy.req_seen", {63'd0, seen}, 64'd1);
        chk("rstbusy.mawb_held", {32'd0, o_MAWB_Rslt}, 64'h0000_ABCD);
        drive_nop();
        #2;
        reset = 1'b1;
        #1;
        chk("rstbusy.req",       {63'd0, o_DMem_req},      64'd0);
        chk("rstbusy.stall",     {63'd0, o_Stall_Req},     64'd0);
        chk("rstbusy.mawb_wb",   {61'd0, o_MAWB_WB},       64'd0);
        chk("rstbusy.mawb_rslt", {32'd0, o_MAWB_Rslt},     64'd0);
        chk("rstbusy.mawb_pc",   {32'd0, o_MAWB_PC},       64'd0);
        chk("rstbusy.mawb_rds",  {59'd0, o_MAWB_Rds_addr}, 64'd0);
        @(posedge clk); #1;
        reset        = 1'b0;
        i_DMem_ack   = 1'b1;
        i_DMem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        i_DMem_ack = 1'b0;
        chk("lateack.req",   {63'd0, o_DMem_req},  64'd0);
        chk("lateack.stall", {63'd0, o_Stall_Req}, 64'd0);
        chk("lateack.rslt",  {32'd0, o_MAWB_Rslt}, 64'd0);
        @(posedge clk); #1;
        chk("lateack.req2",  {63'd0, o_DMem_req},  64'd0);

        // A fresh load after reset still works end to end
        push_exp(3'b011, 32'h2468_ACE0, 32'h0000_0064, 5'd1);
        run_op("loadpost", 3'b011, 2'b01, 32'h80, 32'h0, 32'h64, 5'd1, 1'b0, 32'h0, 1'b0,
               2, 32'h2468_ACE0, 4, 3, 32'h80, 1'b0, 32'h0, 32'h2468_ACE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
